// File: rtl/push_button_debounce.sv
// push_button_debounce
// Conditions raw push-button pins for the GPIO input: each channel gets a
// two-flop synchronizer, a counter-based debounce FSM and one-cycle
// press/release pulses. Sticky event flags with write-1-to-clear feed a
// maskable, registered level interrupt.
module push_button_debounce #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                   sys_clock,
  input  logic                   reset,
  input  logic [NUM_BTN-1:0]     btn_raw_i,
  output logic [NUM_BTN-1:0]     btn_db_o,
  output logic [NUM_BTN-1:0]     press_o,
  output logic [NUM_BTN-1:0]     release_o,
  input  logic [2*NUM_BTN-1:0]   evt_clr_i,
  input  logic [2*NUM_BTN-1:0]   irq_en_i,
  output logic [NUM_BTN-1:0]     evt_press_o,
  output logic [NUM_BTN-1:0]     evt_release_o,
  output logic                   irq_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STABLE0 = 2'd0,
    ST_PEND1   = 2'd1,
    ST_STABLE1 = 2'd2,
    ST_PEND0   = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] w_db;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;

  // Two-flop synchronizer bringing the asynchronous pins into the clock domain.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware does.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw_i;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_db;
    logic             w_db_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_rel;
    logic             w_rel_nxt;
    logic             w_s;

    assign w_s = r_sync2[gi];

    // Debounce state, counter and the registered level/pulse outputs.
    // NOTE: every flop, including the counter, is reset so a button held
    // through reset is re-debounced from scratch afterwards.
    always_ff @(posedge sys_clock) begin
      if (!reset) begin
        r_state <= ST_STABLE0;
        r_cnt   <= '0;
        r_db    <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_db    <= w_db_nxt;
        r_press <= w_press_nxt;
        r_rel   <= w_rel_nxt;
      end
    end

    // Next-state logic: a level is accepted after DEBOUNCE_CYCLES+1 identical
    // synchronized samples; any disagreeing sample returns to the old level.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_db_nxt    = r_db;
      w_press_nxt = 1'b0;
      w_rel_nxt   = 1'b0;
      case (r_state)
        ST_STABLE0: begin
          if (w_s) begin
            w_state_nxt = ST_PEND1;
            w_cnt_nxt   = '0;
          end
        end
        ST_PEND1: begin
          if (!w_s) begin
            w_state_nxt = ST_STABLE0;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_STABLE1;
            w_cnt_nxt   = '0;
            w_db_nxt    = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE1: begin
          if (!w_s) begin
            w_state_nxt = ST_PEND0;
            w_cnt_nxt   = '0;
          end
        end
        ST_PEND0: begin
          if (w_s) begin
            w_state_nxt = ST_STABLE1;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_STABLE0;
            w_cnt_nxt   = '0;
            w_db_nxt    = 1'b0;
            w_rel_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_STABLE0;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_db[gi]      = r_db;
    assign w_press[gi]   = r_press;
    assign w_release[gi] = r_rel;
  end

  assign btn_db_o  = w_db;
  assign press_o   = w_press;
  assign release_o = w_release;

  logic [NUM_BTN-1:0] r_evt_press;
  logic [NUM_BTN-1:0] r_evt_rel;
  logic [NUM_BTN-1:0] w_evt_press_nxt;
  logic [NUM_BTN-1:0] w_evt_rel_nxt;
  logic               r_irq;
  logic               w_irq_nxt;

  // Sticky flags: a pulse sets, a W1C strobe clears, set wins on collision.
  // The interrupt is computed from the next-state flags so a clear or mask
  // takes effect on the very next edge.
  always_comb begin
    w_evt_press_nxt = (r_evt_press & ~evt_clr_i[NUM_BTN-1:0]) | w_press;
    w_evt_rel_nxt   = (r_evt_rel & ~evt_clr_i[2*NUM_BTN-1:NUM_BTN]) | w_release;
    w_irq_nxt       = |({w_evt_rel_nxt, w_evt_press_nxt} & irq_en_i);
  end

  // Event flag and interrupt registers.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_evt_press <= '0;
      r_evt_rel   <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_evt_press <= w_evt_press_nxt;
      r_evt_rel   <= w_evt_rel_nxt;
      r_irq       <= w_irq_nxt;
    end
  end

  assign evt_press_o   = r_evt_press;
  assign evt_release_o = r_evt_rel;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_push_button_debounce.sv
// tb_push_button_debounce
// Scoreboard bench: each stable pin change pushes the expected press/release
// pulse (edge number, pulse bits, new debounced level) into a queue; a
// negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_push_button_debounce;
  localparam int NUM_BTN = 4;
  localparam int DB      = 8;
  // From an input change driven at negedge k, the pulse edge is k+1+2+DB.
  localparam int LAT     = DB + 3;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic [3:0] btn_raw_i;
  logic [3:0] btn_db_o;
  logic [3:0] press_o;
  logic [3:0] release_o;
  logic [7:0] evt_clr_i;
  logic [7:0] irq_en_i;
  logic [3:0] evt_press_o;
  logic [3:0] evt_release_o;
  logic       irq_o;

  always #5 sys_clock = ~sys_clock;

  push_button_debounce #(
    .NUM_BTN         (NUM_BTN),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .sys_clock     (sys_clock),
    .reset         (reset),
    .btn_raw_i     (btn_raw_i),
    .btn_db_o      (btn_db_o),
    .press_o       (press_o),
    .release_o     (release_o),
    .evt_clr_i     (evt_clr_i),
    .irq_en_i      (irq_en_i),
    .evt_press_o   (evt_press_o),
    .evt_release_o (evt_release_o),
    .irq_o         (irq_o)
  );

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] db;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         cyc      = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;
  logic [3:0] model_db = 4'h0;

  always @(posedge sys_clock) cyc <= cyc + 1;

  // Pulse monitor / scoreboard consumer.
  always @(negedge sys_clock) begin
    if (reset === 1'b1 && (press_o | release_o) !== 4'h0) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d press=%h release=%h want no pulse",
                 cyc, press_o, release_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.cyc || press_o !== mon_e.press ||
            release_o !== mon_e.rel || btn_db_o !== mon_e.db) begin
          n_fail++;
          $display("FAIL pulse got cyc=%0d press=%h rel=%h db=%h want cyc=%0d press=%h rel=%h db=%h",
                   cyc, press_o, release_o, btn_db_o,
                   mon_e.cyc, mon_e.press, mon_e.rel, mon_e.db);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  // Drive a new steady pin level and predict the resulting pulses.
  task automatic drive_stable(input logic [3:0] v);
    logic [3:0] chg;
    chg = v ^ model_db;
    if (chg != 4'h0) exp_q.push_back('{cyc + LAT, chg & v, chg & ~v, v});
    model_db  = v;
    btn_raw_i = v;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      tick(1);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic clear_flags();
    evt_clr_i = 8'hFF;
    tick(1);
    evt_clr_i = 8'h00;
  endtask

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic chk_all_zero(input string name);
    logic [20:0] v;
    v = {btn_db_o, press_o, release_o, evt_press_o, evt_release_o, irq_o};
    n_tests++;
    if (v !== 21'h0) begin
      n_fail++;
      $display("FAIL %s outputs got=%h want=0", name, v);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    btn_raw_i = 4'hF;
    evt_clr_i = 8'h00;
    irq_en_i  = 8'h00;
    model_db  = 4'h0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      chk_all_zero("reset_outputs");
      tick(1);
    end
    reset = 1'b1;
    drive_stable(4'hF);
    tick(LAT - 1);
    chk4("reset_db_before", btn_db_o, 4'h0);
    tick(1);
    chk4("reset_db_at", btn_db_o, 4'hF);
    tick(1);
    chk4("reset_press_one_cycle", press_o, 4'h0);
    chk4("reset_evt_press", evt_press_o, 4'hF);
    drain();
  endtask

  task automatic test_glitch();
    drive_stable(4'h0);
    drain();
    clear_flags();
    btn_raw_i[0] = 1'b1;
    tick(DB);
    btn_raw_i[0] = 1'b0;
    tick(15);
    chk4("glitch8_db", btn_db_o, 4'h0);
    chk4("glitch8_evt", evt_press_o, 4'h0);
    exp_q.push_back('{cyc + LAT, 4'h1, 4'h0, 4'h1});
    btn_raw_i[0] = 1'b1;
    tick(DB + 1);
    exp_q.push_back('{cyc + LAT, 4'h0, 4'h1, 4'h0});
    btn_raw_i[0] = 1'b0;
    drain();
    chk4("glitch9_evt_press", evt_press_o, 4'h1);
    chk4("glitch9_evt_release", evt_release_o, 4'h1);
    clear_flags();
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b01101;  // driven LSB first: 1,0,1,1,0
    for (int i = 0; i < 5; i++) begin
      btn_raw_i[2] = pat[i];
      tick(1);
    end
    drive_stable(4'h4);
    drain();
    chk4("bounce_evt_press", evt_press_o, 4'h4);
    chk4("bounce_evt_release", evt_release_o, 4'h0);
    drive_stable(4'h0);
    drain();
    clear_flags();
  endtask

  task automatic test_irq();
    irq_en_i = 8'h02;
    drive_stable(4'h2);
    tick(LAT);
    chk4("irq_evt_in_pulse_cycle", evt_press_o, 4'h0);
    chk1("irq_in_pulse_cycle", irq_o, 1'b0);
    tick(1);
    chk4("irq_evt_set", evt_press_o, 4'h2);
    chk1("irq_rise", irq_o, 1'b1);
    evt_clr_i = 8'h02;
    tick(1);
    evt_clr_i = 8'h00;
    chk4("irq_evt_cleared", evt_press_o, 4'h0);
    chk1("irq_cleared", irq_o, 1'b0);
    drive_stable(4'h0);
    drain();
    chk1("irq_release_masked", irq_o, 1'b0);
    clear_flags();
    drive_stable(4'h2);
    tick(LAT);
    evt_clr_i = 8'h02;
    tick(1);
    evt_clr_i = 8'h00;
    chk4("irq_set_wins", evt_press_o, 4'h2);
    chk1("irq_set_wins_irq", irq_o, 1'b1);
    irq_en_i = 8'h00;
    tick(1);
    chk1("irq_mask_drop", irq_o, 1'b0);
    chk4("irq_mask_flag_kept", evt_press_o, 4'h2);
    drive_stable(4'h0);
    drain();
    clear_flags();
  endtask

  task automatic test_release();
    irq_en_i = 8'h00;
    drive_stable(4'h8);
    drain();
    clear_flags();
    drive_stable(4'h0);
    tick(LAT + 1);
    chk4("rel_pulse_one_cycle", release_o, 4'h0);
    chk4("rel_evt", evt_release_o, 4'h8);
    chk1("rel_irq_masked", irq_o, 1'b0);
    irq_en_i = 8'h80;
    tick(1);
    chk1("rel_irq_enabled", irq_o, 1'b1);
    irq_en_i = 8'h00;
    tick(1);
    chk1("rel_irq_masked_again", irq_o, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    chk4("mid_flag_before", evt_release_o, 4'h8);
    btn_raw_i = 4'h1;
    tick(8);
    chk4("mid_db_pending", btn_db_o, 4'h0);
    reset = 1'b0;
    tick(1);
    chk_all_zero("mid_reset_0");
    tick(1);
    chk_all_zero("mid_reset_1");
    reset = 1'b1;
    drive_stable(4'h1);
    tick(LAT - 1);
    chk4("mid_db_before", btn_db_o, 4'h0);
    drain();
    chk4("mid_evt_press", evt_press_o, 4'h1);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_irq();
    test_release();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout cyc=%0d want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
